mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Consumer end of the EX/MEM interface: load/store unit of the MEM stage.
//  - Takes the registered EX/MEM bundle and issues data-memory requests on a req/gnt/rvalid bus.
//  - Aligns, masks and sign-extends data; stalls upstream until the access completes.
//  - Drives the MEM/WB register bundle. Non-memory ops pass straight through.
// PARAMETERS
//  MAX_WAIT   15   cycles in WAIT_RSP without dmem_rvalid before a bus error is declared (1..255)
// PORTS
//  clk             in   1    single clock, rising edge
//  reset           in   1    asynchronous, active-high
//  valid_m         in   1    EX/MEM bundle holds a live instruction
//  ALUResult_m     in   32   effective address (mem ops) or ALU result
//  WD_m            in   32   store data, unaligned (low bytes significant)
//  PC4_m           in   32   PC+4 passthrough
//  rd_m            in   5    destination register
//  WE_m            in   1    store
//  RE_m            in   1    load; WE_m&RE_m never both 1
//  Size_m          in   2    mem_size_t: SIZE_B / SIZE_H / SIZE_W
//  Unsigned_m      in   1    zero-extend load (LBU/LHU)
//  WE3_m           in   1    register-file write enable
//  ResultSelect_m  in   $bits(result_mux_t)  writeback mux select
//  stall_m         out  1    freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  dmem_req        out  1    request valid; held with addr/we/be/wdata stable until dmem_gnt
//  dmem_we         out  1    1 = write
//  dmem_addr       out  32   word address, {ALUResult_m[31:2],2'b00}
//  dmem_be         out  4    byte enables
//  dmem_wdata      out  32   store data replicated into lanes
//  dmem_gnt        in   1    request accepted this cycle
//  dmem_rvalid     in   1    read data valid
//  dmem_rdata      in   32   read word
//  ReadData_w      out  32   extended load data
//  ALUResult_w     out  32   passthrough
//  PC4_w           out  32   passthrough
//  rd_w            out  5    passthrough
//  WE3_w           out  1    RF write enable; forced 0 on fault or bubble
//  ResultSelect_w  out  $bits(result_mux_t)  passthrough
//  misalign_w      out  1    one-cycle fault flag
//  buserr_w        out  1    one-cycle fault flag
// BEHAVIOUR
//  Reset: FSM=IDLE, wait counter 0, dmem_req=0.
//   - All *_w = 0, except ResultSelect_w=RESULT_ALU.
//   - Takes effect immediately, including mid-transaction.
//   - An rvalid arriving after reset or in IDLE is ignored.
//  FSM IDLE/REQ/WAIT_RSP; a mem op = valid_m&(WE_m|RE_m).
//   - IDLE, no mem op: passthrough registered next edge (latency 1). WE3_w = WE3_m&valid_m.
//   - IDLE, misaligned mem op (H with addr[0]=1, W with addr[1:0]!=0):
//     no request; next edge misalign_w=1, WE3_w=0.
//   - IDLE, aligned mem op: dmem_req asserted combinationally. Then:
//     gnt same cycle -> store completes / load goes to WAIT_RSP;
//     no gnt -> go to REQ.
//   - REQ: hold request until gnt. Then store completes, load -> WAIT_RSP.
//   - WAIT_RSP: counter increments per cycle.
//     rvalid -> load completes, back to IDLE, counter cleared.
//     Counter reaches MAX_WAIT with no rvalid -> buserr_w=1, WE3_w=0, back to IDLE.
//  Completion: MEM/WB regs capture on the completing edge.
//   - Latency: store = gnt cycle+1; load = rvalid cycle+1.
//   - In cycles that do not complete, WE3_w=0 (bubble into WB).
//  stall_m = mem op present & not completing this cycle (combinational).
//   - Not asserted on the completing cycle or for a misaligned op.
//  Byte lanes, off=addr[1:0]:
//   - B: be=1<<off, wdata={4{WD[7:0]}}
//   - H: be=3<<off, wdata={2{WD[15:0]}}
//   - W: be=4'hF, wdata=WD
//  Loads: rdata >> (8*off), then sign- or zero-extend per Size_m/Unsigned_m. W ignores Unsigned_m.
//  Simultaneous gnt & rvalid in REQ: rvalid ignored (it belongs to no outstanding request).
//  Inputs are stable while stall_m=1; never re-sample mid-transaction.
// STRUCTURE
//  Pkg additions:
//   - typedef enum logic [1:0] {SIZE_B,SIZE_H,SIZE_W} mem_size_t
//   - typedef enum {LSU_IDLE,LSU_REQ,LSU_WAIT_RSP} lsu_state_t
//   - result_mux_t / RESULT_ALU are reused from Pkg.
//  Sub-module: lsu_align (combinational): be/wdata generation, load shift/extend, misalign detect.
//  FSM, wait counter and MEM/WB registers live in mem_stage_lsu.
// TESTING
//  1 ALU op, ALUResult_m=32'h1234, WE3_m=1
//    -> next edge ALUResult_w=32'h1234, WE3_w=1, stall_m never 1.
//  2 SB addr=32'h103, WD=32'hAB, gnt after 2 cycles
//    -> dmem_be=4'b1000, dmem_wdata=32'hABABABAB, addr=32'h100.
//    -> stall_m high 2 cycles; req stable until gnt.
//  3 LH addr=32'h102, Unsigned_m=0, rdata=32'h8001_0000, gnt immediate, rvalid 3 cycles later
//    -> ReadData_w=32'hFFFF8001, WE3_w=1. Repeat with LHU -> 32'h00008001.
//  4 LW addr=32'h101
//    -> dmem_req never 1, misalign_w=1 for one cycle, WE3_w=0, stall_m=0.
//  5 LW granted, rvalid withheld
//    -> buserr_w=1 exactly MAX_WAIT cycles after entering WAIT_RSP, WE3_w=0, FSM IDLE.
//  6 Reset asserted in WAIT_RSP
//    -> dmem_req=0 and outputs at reset values immediately.
//    -> rvalid during and after reset ignored; next LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: writeback mux select,
// access size encoding, LSU FSM states and a word-address helper.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2
  } result_mux_t;

  localparam int RESULT_SEL_W = $bits(result_mux_t);

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_REQ      = 2'd1,
    LSU_WAIT_RSP = 2'd2
  } lsu_state_t;

  // Data memory is word addressed on the bus; byte offset travels in the enables
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane logic for the LSU: store enables and lane replication, load
// shift plus sign/zero extension, and natural-alignment checking.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]  addr_off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic        misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic        sign_fill;

  assign shifted = load_word >> {addr_off, 3'b000};

  // Decode size into lane enables, replicated store data and extended load data
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'h0;
    lane_data  = store_data;
    load_data  = shifted;
    sign_fill  = 1'b0;
    case (size)
      SIZE_B: begin
        byte_en   = 4'b0001 << addr_off;
        lane_data = {4{store_data[7:0]}};
        sign_fill = shifted[7] & ~is_unsigned;
        load_data = {{24{sign_fill}}, shifted[7:0]};
      end
      SIZE_H: begin
        misaligned = addr_off[0];
        byte_en    = 4'b0011 << addr_off;
        lane_data  = {2{store_data[15:0]}};
        sign_fill  = shifted[15] & ~is_unsigned;
        load_data  = {{16{sign_fill}}, shifted[15:0]};
      end
      SIZE_W: begin
        misaligned = |addr_off;
        byte_en    = 4'hF;
        lane_data  = store_data;
        load_data  = shifted;
      end
      default: begin
        byte_en = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues req/gnt/rvalid data-memory accesses for
// the EX/MEM bundle, stalls upstream while an access is outstanding, and
// drives the MEM/WB register bundle (non-memory ops pass straight through).
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_m,
  input  logic [31:0]             ALUResult_m,
  input  logic [31:0]             WD_m,
  input  logic [31:0]             PC4_m,
  input  logic [4:0]              rd_m,
  input  logic                    WE_m,
  input  logic                    RE_m,
  input  logic [1:0]              Size_m,
  input  logic                    Unsigned_m,
  input  logic                    WE3_m,
  input  logic [RESULT_SEL_W-1:0] ResultSelect_m,
  output logic                    stall_m,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [31:0]             dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [31:0]             dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [31:0]             dmem_rdata,
  output logic [31:0]             ReadData_w,
  output logic [31:0]             ALUResult_w,
  output logic [31:0]             PC4_w,
  output logic [4:0]              rd_w,
  output logic                    WE3_w,
  output logic [RESULT_SEL_W-1:0] ResultSelect_w,
  output logic                    misalign_w,
  output logic                    buserr_w
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_t  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_op;
  logic        misaligned;
  logic        go;
  logic        req;
  logic        store_done;
  logic        load_done;
  logic        timeout;
  logic        wb_we;
  logic        wb_misalign;
  logic [31:0] load_data;

  lsu_align u_align (
    .addr_off    (ALUResult_m[1:0]),
    .size        (Size_m),
    .is_unsigned (Unsigned_m),
    .store_data  (WD_m),
    .load_word   (dmem_rdata),
    .misaligned  (misaligned),
    .byte_en     (dmem_be),
    .lane_data   (dmem_wdata),
    .load_data   (load_data)
  );

  assign mem_op    = valid_m & (WE_m | RE_m);
  assign go        = mem_op & ~misaligned;
  assign dmem_we   = WE_m;
  assign dmem_addr = word_addr(ALUResult_m);
  assign dmem_req  = req & ~reset;
  assign stall_m   = go & ~(store_done | load_done | timeout) & ~reset;

  // Next-state, bus request, completion and writeback-enable decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req         = 1'b0;
    store_done  = 1'b0;
    load_done   = 1'b0;
    timeout     = 1'b0;
    wb_misalign = 1'b0;
    wb_we       = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (go) begin
          req = 1'b1;
          if (dmem_gnt) begin
            if (WE_m) store_done = 1'b1;
            else      state_d    = LSU_WAIT_RSP;
          end else begin
            state_d = LSU_REQ;
          end
        end else if (mem_op) begin
          wb_misalign = 1'b1;
        end else begin
          wb_we = valid_m & WE3_m;
        end
      end
      LSU_REQ: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (WE_m) begin
            store_done = 1'b1;
            state_d    = LSU_IDLE;
          end else begin
            state_d = LSU_WAIT_RSP;
          end
        end
      end
      LSU_WAIT_RSP: begin
        if (dmem_rvalid) begin
          load_done  = 1'b1;
          state_d    = LSU_IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout    = 1'b1;
          state_d    = LSU_IDLE;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = LSU_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
    if (store_done | load_done) wb_we = WE3_m;
  end

  // FSM state and response-timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // MEM/WB pipeline register; WE3 only survives a clean completion or passthrough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData_w     <= 32'd0;
      ALUResult_w    <= 32'd0;
      PC4_w          <= 32'd0;
      rd_w           <= 5'd0;
      WE3_w          <= 1'b0;
      ResultSelect_w <= RESULT_ALU;
      misalign_w     <= 1'b0;
      buserr_w       <= 1'b0;
    end else begin
      ReadData_w     <= load_done ? load_data : 32'd0;
      ALUResult_w    <= ALUResult_m;
      PC4_w          <= PC4_m;
      rd_w           <= rd_m;
      WE3_w          <= wb_we;
      ResultSelect_w <= ResultSelect_m;
      misalign_w     <= wb_misalign;
      buserr_w       <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the stimulus process plays each
// instruction against a bus responder timeline and queues what the DUT
// should show every cycle; the monitor pops and compares.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int N_RANDOM = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, WE_m, RE_m, Unsigned_m, WE3_m;
  logic [31:0] ALUResult_m, WD_m, PC4_m;
  logic [4:0]  rd_m;
  logic [1:0]  Size_m;
  logic [1:0]  ResultSelect_m;
  logic        stall_m, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] ReadData_w, ALUResult_w, PC4_w;
  logic [4:0]  rd_w;
  logic        WE3_w, misalign_w, buserr_w;
  logic [1:0]  ResultSelect_w;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        uns;
    logic        we3;
    logic [1:0]  rs;
    logic [7:0]  g;
    logic [7:0]  r;
    logic [31:0] rdata;
    logic        noise;
  } instr_t;

  typedef struct packed {
    logic        chk;
    logic        chkPass;
    logic        chkRead;
    logic        we3;
    logic        mis;
    logic        bus;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] read;
    logic [4:0]  rd;
    logic [1:0]  rs;
  } wb_t;

  typedef struct packed {
    logic        expStall;
    logic        expReq;
    logic        chkReq;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    logic        expWe;
    wb_t         wb;
  } cyc_t;

  cyc_t q[$];
  wb_t  prevWb;

  mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .ALUResult_m(ALUResult_m),
    .WD_m(WD_m), .PC4_m(PC4_m), .rd_m(rd_m), .WE_m(WE_m), .RE_m(RE_m),
    .Size_m(Size_m), .Unsigned_m(Unsigned_m), .WE3_m(WE3_m),
    .ResultSelect_m(ResultSelect_m), .stall_m(stall_m), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .ReadData_w(ReadData_w), .ALUResult_w(ALUResult_w),
    .PC4_w(PC4_w), .rd_w(rd_w), .WE3_w(WE3_w), .ResultSelect_w(ResultSelect_w),
    .misalign_w(misalign_w), .buserr_w(buserr_w)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference rules: alignment, lane enables, replicated data, extended load value
  function automatic logic isMisaligned(input instr_t i);
    if (i.size == SIZE_H) return (i.alu % 2) != 0;
    if (i.size == SIZE_W) return (i.alu % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] refBe(input instr_t i);
    int off = int'(i.alu % 4);
    if (i.size == SIZE_B) return 4'(2 ** off);
    if (i.size == SIZE_H) return 4'(3 * (2 ** off));
    return 4'hF;
  endfunction

  function automatic logic [31:0] refWdata(input instr_t i);
    if (i.size == SIZE_B) return (i.wd % 256) * 32'h0101_0101;
    if (i.size == SIZE_H) return (i.wd % 65536) * 32'h0001_0001;
    return i.wd;
  endfunction

  function automatic logic [31:0] refLoad(input instr_t i);
    logic [31:0] v;
    int off = int'(i.alu % 4);
    v = i.rdata >> (8 * off);
    if (i.size == SIZE_B) begin
      v = v % 256;
      if (!i.uns && v >= 128) v = v - 256;
    end else if (i.size == SIZE_H) begin
      v = v % 65536;
      if (!i.uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic instr_t mkInstr(input logic we, input logic re, input logic [1:0] size,
                                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                     input logic we3, input int g, input int r, input logic [31:0] rdata);
    instr_t i;
    i.valid = 1'b1; i.alu = addr; i.wd = wd; i.pc4 = 32'h0000_4000 + addr; i.rd = 5'd7;
    i.we = we; i.re = re; i.size = size; i.uns = uns; i.we3 = we3;
    i.rs = re ? RESULT_MEM : RESULT_ALU;
    i.g = 8'(g); i.r = 8'(r); i.rdata = rdata; i.noise = 1'b0;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    int k = $urandom_range(0, 9);
    int kr = $urandom_range(0, 19);
    i.valid = ($urandom_range(0, 9) != 0);
    i.alu = $urandom; i.wd = $urandom; i.pc4 = $urandom; i.rd = 5'($urandom);
    i.we = (k >= 3 && k <= 5); i.re = (k >= 6);
    i.size = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 3) != 0) i.alu = i.alu - (i.alu % 4) + ((i.size == SIZE_B) ? (i.alu % 4) : ((i.size == SIZE_H) ? 2 * ((i.alu / 2) % 2) : 0));
    i.uns = 1'($urandom); i.we3 = 1'($urandom);
    i.rs = 2'($urandom_range(0, 2));
    i.g = 8'($urandom_range(0, 3));
    if (kr == 0)      i.r = 8'(MAX_WAIT + $urandom_range(0, 2));
    else if (kr == 1) i.r = 8'(MAX_WAIT - 1);
    else              i.r = 8'($urandom_range(0, 3));
    i.rdata = $urandom; i.noise = 1'($urandom);
    return i;
  endfunction

  function automatic wb_t idleWb();
    wb_t w = '0;
    w.chk = 1'b1; w.chkPass = 1'b1; w.rs = RESULT_ALU;
    return w;
  endfunction

  task automatic driveInstr(input instr_t i);
    valid_m = i.valid; ALUResult_m = i.alu; WD_m = i.wd; PC4_m = i.pc4; rd_m = i.rd;
    WE_m = i.we; RE_m = i.re; Size_m = i.size; Unsigned_m = i.uns; WE3_m = i.we3;
    ResultSelect_m = i.rs;
  endtask

  // Play one instruction through its whole bus timeline, queueing per-cycle expectations
  task automatic applyStimulus(input instr_t i);
    logic memOp, mis;
    int   total;
    cyc_t e;
    memOp = i.valid & (i.we | i.re);
    mis   = memOp & isMisaligned(i);
    if (!memOp || mis)       total = 1;
    else if (i.we)           total = i.g + 1;
    else if (i.r < MAX_WAIT) total = i.g + 2 + i.r;
    else                     total = i.g + 1 + MAX_WAIT;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      driveInstr(i);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      e = '0;
      e.wb = prevWb;
      if (memOp && !mis) begin
        if (c <= i.g) begin
          e.expReq = 1'b1; e.chkReq = 1'b1;
          e.expAddr = i.alu - (i.alu % 4); e.expBe = refBe(i);
          e.expWdata = refWdata(i); e.expWe = i.we;
          if (c == i.g) begin
            dmem_gnt = 1'b1;
            dmem_rvalid = i.noise;
          end
        end else if (i.r < MAX_WAIT && c == i.g + 1 + i.r) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = i.rdata;
        end
        e.expStall = (c != total - 1);
      end else begin
        dmem_rvalid = i.noise;
      end
      q.push_back(e);
      prevWb = '0;
      prevWb.chk = 1'b1;
      if (c == total - 1) begin
        if (mis) begin
          prevWb.mis = 1'b1;
        end else if (memOp && i.re && i.r >= MAX_WAIT) begin
          prevWb.bus = 1'b1;
        end else if (i.valid) begin
          prevWb.chkPass = 1'b1;
          prevWb.alu = i.alu; prevWb.pc4 = i.pc4; prevWb.rd = i.rd; prevWb.rs = i.rs;
          prevWb.we3 = i.we3;
          if (memOp && i.re) begin
            prevWb.chkRead = 1'b1;
            prevWb.read = refLoad(i);
          end
        end
      end
    end
  endtask

  // Monitor: compare each queued cycle expectation one time unit before the active edge
  initial begin : monitor
    cyc_t e;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("stall_m", 32'(stall_m), 32'(e.expStall));
        checkOutput("dmem_req", 32'(dmem_req), 32'(e.expReq));
        if (e.chkReq) begin
          checkOutput("dmem_addr", dmem_addr, e.expAddr);
          checkOutput("dmem_be", 32'(dmem_be), 32'(e.expBe));
          checkOutput("dmem_wdata", dmem_wdata, e.expWdata);
          checkOutput("dmem_we", 32'(dmem_we), 32'(e.expWe));
        end
        if (e.wb.chk) begin
          checkOutput("WE3_w", 32'(WE3_w), 32'(e.wb.we3));
          checkOutput("misalign_w", 32'(misalign_w), 32'(e.wb.mis));
          checkOutput("buserr_w", 32'(buserr_w), 32'(e.wb.bus));
          if (e.wb.chkPass) begin
            checkOutput("ALUResult_w", ALUResult_w, e.wb.alu);
            checkOutput("PC4_w", PC4_w, e.wb.pc4);
            checkOutput("rd_w", 32'(rd_w), 32'(e.wb.rd));
            checkOutput("ResultSelect_w", 32'(ResultSelect_w), 32'(e.wb.rs));
          end
          if (e.wb.chkRead) checkOutput("ReadData_w", ReadData_w, e.wb.read);
        end
      end
    end
  end

  // Reset values of every MEM/WB output and of the bus request
  task automatic checkResetState(input string tag);
    checkOutput({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
    checkOutput({tag, " ReadData_w"}, ReadData_w, 32'd0);
    checkOutput({tag, " ALUResult_w"}, ALUResult_w, 32'd0);
    checkOutput({tag, " PC4_w"}, PC4_w, 32'd0);
    checkOutput({tag, " rd_w"}, 32'(rd_w), 32'd0);
    checkOutput({tag, " WE3_w"}, 32'(WE3_w), 32'd0);
    checkOutput({tag, " ResultSelect_w"}, 32'(ResultSelect_w), 32'(RESULT_ALU));
    checkOutput({tag, " misalign_w"}, 32'(misalign_w), 32'd0);
    checkOutput({tag, " buserr_w"}, 32'(buserr_w), 32'd0);
  endtask

  initial begin : stimulus
    instr_t bubble, lw;
    cyc_t   e;
    bubble = '0;
    bubble.rs = RESULT_ALU;
    reset = 1'b1;
    driveInstr(bubble);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #3;
    checkResetState("por");
    @(negedge clk);
    reset = 1'b0;
    prevWb = idleWb();

    $display("[TB] directed sequences");
    applyStimulus(mkInstr(1'b0, 1'b0, SIZE_W, 1'b0, 32'h1234, 32'h0, 1'b1, 0, 0, 32'h0));
    applyStimulus(mkInstr(1'b1, 1'b0, SIZE_B, 1'b0, 32'h103, 32'hAB, 1'b0, 2, 0, 32'h0));
    applyStimulus(mkInstr(1'b0, 1'b1, SIZE_H, 1'b0, 32'h102, 32'h0, 1'b1, 0, 2, 32'h8001_0000));
    applyStimulus(mkInstr(1'b0, 1'b1, SIZE_H, 1'b1, 32'h102, 32'h0, 1'b1, 0, 2, 32'h8001_0000));
    applyStimulus(mkInstr(1'b0, 1'b1, SIZE_W, 1'b0, 32'h101, 32'h0, 1'b1, 0, 0, 32'h0));
    applyStimulus(mkInstr(1'b0, 1'b1, SIZE_W, 1'b0, 32'h200, 32'h0, 1'b1, 1, MAX_WAIT, 32'h0));
    applyStimulus(mkInstr(1'b0, 1'b1, SIZE_B, 1'b0, 32'h203, 32'h0, 1'b1, 0, MAX_WAIT - 1, 32'h7F00_0000));
    applyStimulus(mkInstr(1'b1, 1'b0, SIZE_H, 1'b0, 32'h206, 32'h1234_BEEF, 1'b0, 0, 0, 32'h0));

    $display("[TB] random sequence");
    for (int n = 0; n < N_RANDOM; n++) applyStimulus(randInstr());

    $display("[TB] reset during WAIT_RSP");
    lw = mkInstr(1'b0, 1'b1, SIZE_W, 1'b0, 32'h300, 32'h5555_AAAA, 1'b1, 0, 0, 32'h0);
    @(negedge clk);
    driveInstr(lw);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
    e = '0;
    e.wb = prevWb;
    e.expStall = 1'b1; e.expReq = 1'b1; e.chkReq = 1'b1;
    e.expAddr = 32'h300; e.expBe = 4'hF; e.expWdata = lw.wd; e.expWe = 1'b0;
    q.push_back(e);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2;
    reset = 1'b1;
    driveInstr(bubble);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checkResetState("mid-wait reset");
    checkOutput("stall_m in reset", 32'(stall_m), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prevWb = idleWb();
    bubble.noise = 1'b1;
    applyStimulus(bubble);
    applyStimulus(mkInstr(1'b0, 1'b1, SIZE_W, 1'b0, 32'h400, 32'h0, 1'b1, 1, 1, 32'hCAFE_F00D));
    bubble.noise = 1'b0;
    applyStimulus(bubble);
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
